// File: rtl/fifo_serial_tx_if.sv
// FIFO read-port bundle between a show-ahead FIFO and its drain-side consumer.
//   fifo_empty : FIFO empty flag (driven by the FIFO)
//   fifo_data  : FIFO head word, valid while fifo_empty=0 (driven by the FIFO)
//   fifo_read  : one-cycle pop strobe (driven by the consumer)
// master = FIFO side, slave = consumer side.
interface fifo_serial_tx_if #(
  parameter int DATA_W = 16
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read;

  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_read
  );

  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Drain-side serial transmitter for a show-ahead FIFO. When enabled and the
// FIFO is non-empty it pops one word and sends it LSB-first as a frame:
// start bit (0), DATA_W data bits, optional even parity, stop bit (1).
// Ports:
//   clock       : rising-edge clock
//   reset       : synchronous, active-high
//   enable      : permits starting a new frame (sampled only in IDLE)
//   fifo        : FIFO read port (fifo_empty, fifo_data in; fifo_read out)
//   tx          : serial line, idle-high
//   busy        : high while a frame is in progress
//   frame_done  : one-cycle pulse in the first IDLE cycle after a stop bit
//   frame_count : completed-frame counter, wraps 255->0
// All outputs are registered.
module fifo_serial_tx #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  fifo_serial_tx_if.slave         fifo,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              frame_count
);

  localparam int         CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [7:0]          baud_q, baud_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                read_q, read_d;
  logic                done_q, done_d;
  logic [7:0]          count_q, count_d;
  logic                baud_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      read_q  <= read_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    read_d    = 1'b0;
    done_d    = 1'b0;
    count_d   = count_q;
    baud_last = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (enable && !fifo.fifo_empty) begin
          shift_d = fifo.fifo_data;
          // Parity is taken from the captured word so later FIFO head
          // changes cannot affect the frame in flight.
          par_d   = ^fifo.fifo_data;
          read_d  = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // Line always shows shift_q[0]; shifting first exposes the next bit.
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + CNT_W'(1);
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end

      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx             = tx_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign frame_count    = count_q;
  assign fifo.fifo_read = read_q;

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Drain-side consumer for the 16-bit show-ahead FIFO. Whenever it is enabled and the FIFO reports non-empty, it pops one word and sends it LSB-first on a single-wire asynchronous serial line. Each word goes out as one frame: start bit, data bits, optional even parity, stop bit. It sits between the FIFO's read port and the off-chip serial link, and is the transmit end of the link whose receiver fills the FIFO.

## Interface
- DATA_W, 16, word width; must equal FIFO data width.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
- PARITY_EN, 1, 1 inserts an even-parity bit after data, 0 omits it.

- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO head word, valid while fifo_empty=0.
- fifo_read  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle-high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse at end of each stop bit.
- frame_count  output  8  completed-frame counter; wraps 255->0.

## Operation
- All outputs are registered.
- Reset values: tx=1, fifo_read=0, busy=0, frame_done=0, frame_count=0, state=IDLE. Shift register, bit counter and baud counter are cleared.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** tx=1, busy=0.
  - On an edge with enable=1 and fifo_empty=0: shift_reg<=fifo_data, fifo_read<=1, tx<=0, busy<=1, baud counter<=0, bit counter<=0, state<=START.
- **START:** tx=0 for CLKS_PER_BIT cycles, then state<=DATA with tx<=shift_reg[0].
- **DATA:** each bit is held CLKS_PER_BIT cycles, then shift right and increment the bit counter.
  - After bit DATA_W-1 completes: go to PARITY if PARITY_EN=1, else STOP.
- **PARITY:** tx = XOR of the captured word, so the total count of ones including the parity bit is even. Held CLKS_PER_BIT cycles, then STOP.
- **STOP:** tx=1 for CLKS_PER_BIT cycles. On the last-cycle edge: state<=IDLE, busy<=0, frame_done<=1 for one cycle, frame_count<=frame_count+1 (8-bit wrap).
- **fifo_read:** exactly one pulse per frame, high in the cycle after the capture edge. The FIFO pops on the following edge. No pop is issued outside a capture.
- **Parity:** computed from the captured word, not the live fifo_data.
- **enable:** deasserting it mid-frame does not abort the frame; it only blocks the next capture.
- **fifo_empty:** ignored outside IDLE.
- **Reset mid-frame:** next edge forces all reset values. The popped word is discarded, the frame is truncated, and tx returns high immediately.

## Timing
- Frame length F = (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles. Defaults: 19×4 = 76.
- tx falls on the capture edge. Stop bit ends F cycles later.
- Minimum gap between frames is 1 IDLE cycle with tx=1. The next capture happens on the edge after STOP exits, if enable=1 and fifo_empty=0.
- Back-to-back period is therefore F+1 cycles.
- fifo_read high in cycle 1 of START (relative cycle 0 = capture edge). frame_done high in the first IDLE cycle.
- Bit k of the word is driven from cycle (1+k)×CLKS_PER_BIT to (2+k)×CLKS_PER_BIT−1 after the capture edge.
- CLKS_PER_BIT=1: every state lasts one cycle. No zero-length states are permitted.

## Test plan
- **Single word, defaults:** fifo_data=16'hA5C3, empty 1->0, enable=1.
  - tx low 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (4 cycles each), parity 0, stop 1.
  - One fifo_read pulse; frame_done after 76 cycles; frame_count=1.
- **Parity check:** word 16'h0001 with PARITY_EN=1 -> parity bit 1. Same word with PARITY_EN=0 -> no parity bit, frame 72 cycles.
- **Back-to-back:** 3 words queued, empty held low.
  - Exactly 3 fifo_read pulses, frames spaced 77 cycles, single idle cycle of tx=1 between them, frame_count=3.
- **Empty / disabled:**
  - empty=1, enable=1 for 200 cycles -> tx=1, busy=0, no fifo_read.
  - enable dropped mid-frame -> current frame completes, no further capture.
- **Reset mid-frame:** reset asserted in DATA bit 7 for 1 cycle.
  - Next cycle: tx=1, busy=0, frame_count unchanged at 0.
  - Restart with a new word transmits it correctly.
- **Counter wrap:** CLKS_PER_BIT=1, 257 frames.
  - frame_count reads 255 -> 0 -> 1, with 257 frame_done pulses.
